if_pc_gen: RTL and testbench
============================

Name: if_pc_gen

Overview:
- Instruction-fetch PC generator and fetch sequencer; sits directly upstream of the branch-prediction/BTB controller.
- Drives the current fetch PC to the BTB for lookup and consumes the BTB's taken prediction, predicted target and misprediction flag to select the next PC.
- Issues one-outstanding fetch requests to instruction memory and presents fetched instructions, with their PC and prediction bit, to decode.
- Honours pipeline hold through a 1-entry skid buffer.

Parameters:
- ADDR_W, 64, width of PC/address buses.
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction value driven when no valid instruction.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- hold_i  input  1  pipeline hold from hazard control; 1 = decode must not advance
- jmp_prediction_i  input  1  BTB taken prediction for pc_o (combinational on pc_o)
- target_pred_i  input  ADDR_W  BTB predicted target for pc_o
- prediction_error_i  input  1  BTB misprediction flag from resolve stage
- redirect_pc_i  input  ADDR_W  correct next PC, valid when prediction_error_i=1
- pc_o  output  ADDR_W  current fetch PC (BTB lookup address)
- if_req_o  output  1  fetch request valid
- if_addr_o  output  ADDR_W  fetch address, equals pc_o
- if_gnt_i  input  1  memory accepts request this cycle
- if_rvalid_i  input  1  response valid
- if_rdata_i  input  32  response instruction
- inst_valid_o  output  1  instruction to decode valid
- inst_o  output  32  instruction to decode
- inst_pc_o  output  ADDR_W  PC of inst_o
- inst_pred_o  output  1  prediction bit used when inst_o was fetched

Behaviour:
- One clock domain; clk and rst are the only clock and reset; reset is synchronous and active-high.
- Reset: pc_q=RESET_PC, state=IDLE, kill_q=0, out/skid valid=0, if_req_o=0, inst_valid_o=0, inst_o=NOP_INST, inst_pc_o=0, inst_pred_o=0. Reset mid-transaction drops all outstanding state; a late if_rvalid_i in the first cycle after reset is ignored.
- FSM:
  - IDLE: one cycle after reset, then REQ.
  - REQ: if_req_o=1 unless skid_valid=1. On if_req_o&&if_gnt_i: latch req_pc=pc_q, req_pred=jmp_prediction_i, go to WAIT, and load pc_q with the next PC.
  - WAIT: if_req_o=0. On if_rvalid_i: go to REQ.
- Next-PC priority (applies in any state): prediction_error_i → redirect_pc_i; else, on grant, jmp_prediction_i ? target_pred_i : pc_q+4. pc_q is unchanged otherwise.
- Redirect addresses have bits [1:0] forced to 0. pc_q+4 wraps modulo 2^ADDR_W.
- Minimum fetch cadence is 2 cycles per instruction (grant, then response); back-to-back overlap is not supported.
- Response in WAIT with kill_q=0 writes {if_rdata_i, req_pc, req_pred}:
  - to the out register if out is empty or being consumed (!hold_i);
  - else to skid.
- Response with kill_q=1 is discarded and kill_q is cleared.
- Out register is consumed each cycle hold_i=0. Skid drains into out on the first cycle hold_i=0, and has priority over a same-cycle response. That cannot happen, since REQ stalls while skid_valid=1.
- prediction_error_i=1:
  - out and skid are invalidated the same cycle (inst_valid_o=0 next cycle, inst_o=NOP_INST);
  - kill_q=1 if in WAIT without same-cycle if_rvalid_i, or if in REQ with a same-cycle grant;
  - prediction_error_i overrides hold_i for flush and PC update.
- hold_i never blocks PC redirect; it only freezes out/skid and, via skid full, stops new requests.
- inst_o=NOP_INST and inst_pred_o=0 whenever inst_valid_o=0.

Test Plan:
- Reset, then if_gnt_i=1 and 1-cycle rvalid returning 0x00100093 → pc_o sequence 0x80000000, 0x80000004, 0x80000008; inst_pc_o=0x80000000 with inst_valid_o 3 cycles after reset release.
- BTB jmp_prediction_i=1, target_pred_i=0x80000100 at pc 0x80000008 → next if_addr_o=0x80000100; that instruction has inst_pred_o=1.
- prediction_error_i=1, redirect_pc_i=0x80000042 while in WAIT → pc_o=0x80000040; the in-flight response is discarded (no inst_valid_o); next request goes to 0x80000040.
- hold_i=1 for 6 cycles with out valid, response arrives → captured in skid, no further if_req_o. On release, out then skid are presented on consecutive cycles in order, and requests resume.
- prediction_error_i and hold_i both 1 with out and skid valid → both invalidated, inst_valid_o=0, pc_o=redirect.
- rst=1 asserted while in WAIT → next cycle pc_o=RESET_PC, if_req_o=0, inst_valid_o=0; a stray if_rvalid_i is ignored.

Source files
------------

// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator and fetch sequencer.
// Keeps the fetch PC and looks it up in the BTB. It issues one outstanding
// fetch request at a time to instruction memory, and hands fetched
// instructions to decode through an output register backed by a 1-entry skid
// buffer. A BTB misprediction redirects the PC and flushes all buffered or
// in-flight work.
module if_pc_gen #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  // hazard control
  input  logic              hold_i,
  // BTB interface
  input  logic              jmp_prediction_i,
  input  logic [ADDR_W-1:0] target_pred_i,
  input  logic              prediction_error_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] pc_o,
  // instruction memory
  output logic              if_req_o,
  output logic [ADDR_W-1:0] if_addr_o,
  input  logic              if_gnt_i,
  input  logic              if_rvalid_i,
  input  logic [31:0]       if_rdata_i,
  // decode
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_pred_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // One fetched instruction together with its fetch context.
  typedef struct packed {
    logic [31:0]       inst;
    logic [ADDR_W-1:0] pc;
    logic              pred;
  } fetch_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_req_pred;
  logic              r_kill;

  logic              r_out_v;
  fetch_t            r_out;
  logic              r_skid_v;
  fetch_t            r_skid;

  logic              w_grant;
  logic              w_resp;
  logic              w_kill_set;
  logic [ADDR_W-1:0] w_redirect;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_next;
  fetch_t            w_resp_ent;
  logic              w_unused_redir_lsbs;

  // Instructions are word aligned, so the low redirect bits carry no information.
  assign w_redirect          = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign w_unused_redir_lsbs = ^redirect_pc_i[1:0];
  assign w_pc_inc            = r_pc + ADDR_W'(4);

  // A full skid means decode is backed up, so no new fetch is started.
  assign if_req_o  = (r_state == S_REQ) && !r_skid_v;
  assign if_addr_o = r_pc;
  assign pc_o      = r_pc;
  assign w_grant   = if_req_o && if_gnt_i;

  // A response is usable only if nothing killed it, before or during its arrival.
  assign w_resp = (r_state == S_WAIT) && if_rvalid_i && !r_kill && !prediction_error_i;

  // The in-flight fetch belongs to the wrong path once a mispredict is seen
  // with a request granted but not yet answered.
  assign w_kill_set = prediction_error_i &&
                      (((r_state == S_WAIT) && !if_rvalid_i) || w_grant);

  // Next-PC select: a mispredict wins, then a granted fetch advances.
  always_comb begin
    w_pc_next = r_pc;
    if (prediction_error_i)
      w_pc_next = w_redirect;
    else if (w_grant)
      w_pc_next = jmp_prediction_i ? target_pred_i : w_pc_inc;
  end

  // Payload captured from a memory response.
  always_comb begin
    w_resp_ent      = '0;
    w_resp_ent.inst = if_rdata_i;
    w_resp_ent.pc   = r_req_pc;
    w_resp_ent.pred = r_req_pred;
  end

  // Fetch sequencer: PC register, request context and the kill flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_req_pred <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      case (r_state)
        // Spend one cycle here so a response left over from before reset is dropped.
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (w_grant) begin
            r_state    <= S_WAIT;
            r_req_pc   <= r_pc;
            r_req_pred <= jmp_prediction_i;
          end
        end
        S_WAIT: begin
          if (if_rvalid_i)
            r_state <= S_REQ;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_kill_set)
        r_kill <= 1'b1;
      else if ((r_state == S_WAIT) && if_rvalid_i)
        r_kill <= 1'b0;
    end
  end

  // Decode-side buffering: out register plus a skid entry that only fills
  // when a response lands while out is valid and held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_v      <= 1'b0;
      r_out        <= '0;
      r_out.inst   <= NOP_INST;
      r_skid_v     <= 1'b0;
      r_skid       <= '0;
    end else if (prediction_error_i) begin
      // A flush ignores hold: wrong-path instructions must never reach decode.
      r_out_v      <= 1'b0;
      r_out.inst   <= NOP_INST;
      r_out.pred   <= 1'b0;
      r_skid_v     <= 1'b0;
    end else if (!hold_i) begin
      if (r_skid_v) begin
        // The older skid entry goes first. A response cannot arrive in the same
        // cycle because requests are blocked while the skid is full.
        r_out_v    <= 1'b1;
        r_out      <= r_skid;
        r_skid_v   <= 1'b0;
      end else if (w_resp) begin
        r_out_v    <= 1'b1;
        r_out      <= w_resp_ent;
      end else begin
        r_out_v    <= 1'b0;
        r_out.inst <= NOP_INST;
        r_out.pred <= 1'b0;
      end
    end else if (w_resp) begin
      if (!r_out_v) begin
        r_out_v    <= 1'b1;
        r_out      <= w_resp_ent;
      end else begin
        r_skid_v   <= 1'b1;
        r_skid     <= w_resp_ent;
      end
    end
  end

  assign inst_valid_o = r_out_v;
  assign inst_o       = r_out.inst;
  assign inst_pc_o    = r_out.pc;
  assign inst_pred_o  = r_out.pred;

endmodule

// File: tb/tb_if_pc_gen.sv
// Bench for if_pc_gen. The stimulus drives directed vectors and queues the
// instructions decode is expected to consume. A memory responder answers each
// granted fetch after a programmable latency. A separate monitor pops the queue
// whenever decode consumes an instruction.
module tb_if_pc_gen;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        hold_i;
  logic        jmp_prediction_i;
  logic [63:0] target_pred_i;
  logic        prediction_error_i;
  logic [63:0] redirect_pc_i;
  logic [63:0] pc_o;
  logic        if_req_o;
  logic [63:0] if_addr_o;
  logic        if_gnt_i;
  logic        if_rvalid_i;
  logic [31:0] if_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        inst_pred_o;

  if_pc_gen dut (
    .clk                (clk),
    .rst                (rst),
    .hold_i             (hold_i),
    .jmp_prediction_i   (jmp_prediction_i),
    .target_pred_i      (target_pred_i),
    .prediction_error_i (prediction_error_i),
    .redirect_pc_i      (redirect_pc_i),
    .pc_o               (pc_o),
    .if_req_o           (if_req_o),
    .if_addr_o          (if_addr_o),
    .if_gnt_i           (if_gnt_i),
    .if_rvalid_i        (if_rvalid_i),
    .if_rdata_i         (if_rdata_i),
    .inst_valid_o       (inst_valid_o),
    .inst_o             (inst_o),
    .inst_pc_o          (inst_pc_o),
    .inst_pred_o        (inst_pred_o)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        pred;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   lat    = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory image: address 0x80000000 returns 0x00100093.
  function automatic logic [31:0] mkinst(input logic [63:0] a);
    return 32'h0010_0093 ^ {a[23:0], 8'h00};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", nm, act, exp);
    end
  endtask

  task automatic exp_push(input logic [63:0] pc, input logic pred);
    exp_t e;
    e.pc   = pc;
    e.inst = mkinst(pc);
    e.pred = pred;
    sbq.push_back(e);
  endtask

  // Stimulus acts 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory responder: sees a grant coming at the falling edge, answers lat cycles later.
  initial begin
    logic        pend;
    int          cnt;
    logic [63:0] paddr;
    pend        = 1'b0;
    cnt         = 0;
    paddr       = '0;
    if_rvalid_i = 1'b0;
    if_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if_rvalid_i = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          if_rvalid_i = 1'b1;
          if_rdata_i  = mkinst(paddr);
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (if_req_o === 1'b1 && if_gnt_i === 1'b1) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = if_addr_o;
      end
    end
  end

  // Monitor: every instruction decode consumes must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && inst_valid_o === 1'b1 && hold_i === 1'b0) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_inst: got pc=%h inst=%h, required no instruction",
                   inst_pc_o, inst_o);
        end else begin
          e = sbq.pop_front();
          chk("mon_pc", inst_pc_o, e.pc);
          chk("mon_inst", 64'(inst_o), 64'(e.inst));
          chk1("mon_pred", inst_pred_o, e.pred);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; hold_i = 1'b0; jmp_prediction_i = 1'b0; target_pred_i = '0;
    prediction_error_i = 1'b0; redirect_pc_i = '0; if_gnt_i = 1'b1; lat = 1;
    repeat (3) tick();
    chk("rst_pc", pc_o, RST_PC);
    chk1("rst_req", if_req_o, 1'b0);
    chk1("rst_valid", inst_valid_o, 1'b0);
    chk("rst_inst", 64'(inst_o), 64'(NOP));
    chk1("rst_pred", inst_pred_o, 1'b0);
    chk("rst_inst_pc", inst_pc_o, 64'h0);

    // Sequential fetch with 1-cycle memory latency.
    exp_push(64'h8000_0000, 1'b0);
    exp_push(64'h8000_0004, 1'b0);
    rst = 1'b0;
    tick();  // IDLE -> REQ
    chk("seq_pc0", pc_o, 64'h8000_0000);
    chk1("seq_req0", if_req_o, 1'b1);
    tick();  // grant 0x80000000
    chk("seq_pc1", pc_o, 64'h8000_0004);
    chk1("seq_wait_req", if_req_o, 1'b0);
    tick();  // response lands in out
    chk1("seq_valid0", inst_valid_o, 1'b1);
    chk("seq_inst_pc0", inst_pc_o, 64'h8000_0000);
    chk1("seq_req1", if_req_o, 1'b1);
    tick();
    chk("seq_pc2", pc_o, 64'h8000_0008);
    chk1("seq_valid_gap", inst_valid_o, 1'b0);
    tick();

    // BTB predicts taken at 0x80000008.
    chk("btb_addr", if_addr_o, 64'h8000_0008);
    exp_push(64'h8000_0008, 1'b1);
    jmp_prediction_i = 1'b1;
    target_pred_i    = 64'h8000_0100;
    tick();
    chk("btb_target", if_addr_o, 64'h8000_0100);
    jmp_prediction_i = 1'b0;
    tick();
    chk1("btb_pred_bit", inst_pred_o, 1'b1);
    exp_push(64'h8000_0100, 1'b0);
    tick();
    lat = 3;
    tick();
    chk("pc_after_target", if_addr_o, 64'h8000_0104);

    // Mispredict while the 0x80000104 fetch is outstanding.
    tick();
    chk("wait_pc", pc_o, 64'h8000_0108);
    chk1("wait_req", if_req_o, 1'b0);
    prediction_error_i = 1'b1;
    redirect_pc_i      = 64'h8000_0042;
    tick();
    chk("redir_pc", pc_o, 64'h8000_0040);
    chk1("redir_req", if_req_o, 1'b0);
    chk1("redir_valid", inst_valid_o, 1'b0);
    prediction_error_i = 1'b0;
    lat = 1;
    exp_push(64'h8000_0040, 1'b0);
    tick();
    chk1("kill_still_wait", if_req_o, 1'b0);
    tick();  // stale response arrives and is dropped
    chk1("kill_no_valid", inst_valid_o, 1'b0);
    chk1("kill_req", if_req_o, 1'b1);
    chk("kill_addr", if_addr_o, 64'h8000_0040);
    tick();
    chk("redir_next_pc", pc_o, 64'h8000_0044);
    tick();
    chk1("redir_inst_valid", inst_valid_o, 1'b1);
    chk("redir_inst_pc", inst_pc_o, 64'h8000_0040);

    // Hold for 6 cycles: the next response goes to skid and fetch stalls.
    hold_i = 1'b1;
    exp_push(64'h8000_0044, 1'b0);
    tick();
    tick();  // response captured in skid
    chk1("skid_req", if_req_o, 1'b0);
    chk("hold_inst_pc", inst_pc_o, 64'h8000_0040);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("hold_req", if_req_o, 1'b0);
      chk1("hold_valid", inst_valid_o, 1'b1);
    end
    hold_i = 1'b0;
    tick();  // skid drains into out
    chk1("drain_valid", inst_valid_o, 1'b1);
    chk("drain_inst_pc", inst_pc_o, 64'h8000_0044);
    chk1("drain_req", if_req_o, 1'b1);
    tick();
    chk1("drain_empty", inst_valid_o, 1'b0);
    chk("drain_pc", pc_o, 64'h8000_004c);
    tick();
    chk("fill_inst_pc", inst_pc_o, 64'h8000_0048);

    // Mispredict with hold, out and skid both valid.
    hold_i = 1'b1;
    tick();
    chk("fill_pc", pc_o, 64'h8000_0050);
    tick();
    chk1("both_full_req", if_req_o, 1'b0);
    chk1("both_full_valid", inst_valid_o, 1'b1);
    prediction_error_i = 1'b1;
    redirect_pc_i      = 64'h8000_0203;
    tick();
    chk1("flush_valid", inst_valid_o, 1'b0);
    chk("flush_inst", 64'(inst_o), 64'(NOP));
    chk1("flush_pred", inst_pred_o, 1'b0);
    chk("flush_pc", pc_o, 64'h8000_0200);
    chk1("flush_req", if_req_o, 1'b1);
    prediction_error_i = 1'b0;
    hold_i = 1'b0;
    lat = 2;
    exp_push(64'h8000_0200, 1'b0);
    tick();
    tick();
    chk("flush_next_inst_pc", inst_pc_o, 64'h8000_0200);

    // Reset while a fetch is outstanding; its response turns up right after reset.
    tick();
    chk("pre_rst_pc", pc_o, 64'h8000_0208);
    chk1("pre_rst_req", if_req_o, 1'b0);
    rst = 1'b1;
    tick();
    chk("midrst_pc", pc_o, RST_PC);
    chk1("midrst_req", if_req_o, 1'b0);
    chk1("midrst_valid", inst_valid_o, 1'b0);
    rst = 1'b0;
    tick();  // stray response sampled in IDLE
    chk1("stray_valid", inst_valid_o, 1'b0);
    chk1("stray_req", if_req_o, 1'b1);
    chk("stray_pc", pc_o, RST_PC);
    exp_push(RST_PC, 1'b0);
    tick();
    chk("post_rst_pc", pc_o, 64'h8000_0004);
    tick();
    chk1("post_rst_wait", inst_valid_o, 1'b0);
    tick();
    chk1("post_rst_valid", inst_valid_o, 1'b1);
    chk("post_rst_inst_pc", inst_pc_o, RST_PC);
    tick();
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
